corr_bin_dispatcher: RTL and testbench

Parametrised time-correlation histogram address generator with buffered increment requests. It accepts timestamp-difference events tagged with start/end channel codes, classifies them against a programmable reference/probe channel pair, and converts the signed delay into a histogram bin address centred at mid-range. The resulting bin addresses are queued to the histogram memory's read-modify-write engine through a valid/ready handshake. Per-category event statistics are kept.

---
 rtl/corr_pkg.sv | 17 +
 rtl/corr_sync_fifo.sv | 47 ++++
 rtl/corr_bin_dispatcher.sv | 141 ++++++++++++++
 tb/tb_corr_bin_dispatcher.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Shared types and helpers for the correlation histogram dispatcher.
package corr_pkg;

    typedef enum logic [1:0] {CLS_FWD, CLS_REV, CLS_ZERO, CLS_REJ} evt_cls_e;

    function automatic int unsigned center_of(input int unsigned addr_w);
        return 32'd1 << (addr_w - 1);
    endfunction

    // Increment that sticks at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] top;
        top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= top) ? top : v + 64'd1;
    endfunction

endpackage

// File: rtl/corr_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module corr_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign valid_o = (cnt_q != '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/corr_bin_dispatcher.sv
// Classifies start/end channel delay events into histogram bin addresses and
// queues the resulting increment requests towards the RMW engine.
module corr_bin_dispatcher
    import corr_pkg::*;
#(
    parameter int CH_W   = 2,
    parameter int INT_W  = 7,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_enable,
    input  logic              cfg_mirror,
    input  logic [CH_W-1:0]   cfg_ref_ch,
    input  logic [CH_W-1:0]   cfg_probe_ch,
    input  logic              evt_valid,
    output logic              evt_ready,
    input  logic [CH_W-1:0]   evt_start_ch,
    input  logic [CH_W-1:0]   evt_end_ch,
    input  logic [INT_W-1:0]  evt_interval,
    output logic              inc_valid,
    input  logic              inc_ready,
    output logic [ADDR_W-1:0] inc_addr,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  accept_cnt,
    output logic [CNT_W-1:0]  reject_cnt,
    output logic [CNT_W-1:0]  range_cnt
);
    localparam int AW  = ((ADDR_W > INT_W) ? ADDR_W : INT_W) + 1;
    localparam int FCW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] CTR = AW'(center_of(ADDR_W));

    logic              rdy_q, rdy_d;
    logic              s1_vld_q, s1_vld_d;
    logic              s1_push_q, s1_push_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]  rej_cnt_q, rej_cnt_d;
    logic [CNT_W-1:0]  rng_cnt_q, rng_cnt_d;

    evt_cls_e          cls;
    logic [AW-1:0]     ivl, sum;
    logic              in_rng, fwd_hit, rev_hit, acc;
    logic              push, pop, fifo_vld;
    logic [ADDR_W-1:0] fifo_data;
    logic [FCW-1:0]    fifo_cnt, fifo_cnt_d;

    assign acc     = evt_valid && rdy_q;
    assign fwd_hit = (evt_start_ch == cfg_ref_ch)   && (evt_end_ch == cfg_probe_ch);
    assign rev_hit = (evt_start_ch == cfg_probe_ch) && (evt_end_ch == cfg_ref_ch);
    assign ivl     = AW'(evt_interval);

    // Range checks happen at the widened width so no address can wrap.
    always_comb begin
        cls = CLS_REJ;
        if (fwd_hit || rev_hit) begin
            if (evt_interval == '0)        cls = CLS_ZERO;
            else if (fwd_hit || cfg_mirror) cls = CLS_FWD;
            else                            cls = CLS_REV;
        end
        in_rng = 1'b0;
        sum    = CTR;
        case (cls)
            CLS_FWD:  begin in_rng = (ivl <= CTR - AW'(1)); sum = CTR + ivl; end
            CLS_REV:  begin in_rng = (ivl <= CTR);          sum = CTR - ivl; end
            CLS_ZERO: begin in_rng = 1'b1;                  sum = CTR;       end
            default:  begin in_rng = 1'b0;                  sum = CTR;       end
        endcase
    end

    always_comb begin
        acc_cnt_d = acc_cnt_q;
        rej_cnt_d = rej_cnt_q;
        rng_cnt_d = rng_cnt_q;
        if (clr_cnt) begin
            acc_cnt_d = '0;
            rej_cnt_d = '0;
            rng_cnt_d = '0;
        end else if (acc && cfg_enable) begin
            if (cls == CLS_REJ) rej_cnt_d = CNT_W'(sat_inc(64'(rej_cnt_q), CNT_W));
            else if (!in_rng)   rng_cnt_d = CNT_W'(sat_inc(64'(rng_cnt_q), CNT_W));
            else                acc_cnt_d = CNT_W'(sat_inc(64'(acc_cnt_q), CNT_W));
        end
    end

    assign s1_vld_d  = acc;
    assign s1_push_d = acc && cfg_enable && (cls != CLS_REJ) && in_rng;
    assign s1_addr_d = acc ? ADDR_W'(sum) : s1_addr_q;

    assign push = s1_vld_q && s1_push_q;
    assign pop  = fifo_vld && inc_ready;

    // Ready is registered from the next-cycle occupancy, so a pop only frees
    // a slot one cycle later and stage1 always has a guaranteed home.
    assign fifo_cnt_d = fifo_cnt + FCW'(push) - FCW'(pop);
    assign rdy_d      = (int'(fifo_cnt_d) + int'(s1_vld_d)) < DEPTH;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q     <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_push_q <= 1'b0;
            s1_addr_q <= '0;
            acc_cnt_q <= '0;
            rej_cnt_q <= '0;
            rng_cnt_q <= '0;
        end else begin
            rdy_q     <= rdy_d;
            s1_vld_q  <= s1_vld_d;
            s1_push_q <= s1_push_d;
            s1_addr_q <= s1_addr_d;
            acc_cnt_q <= acc_cnt_d;
            rej_cnt_q <= rej_cnt_d;
            rng_cnt_q <= rng_cnt_d;
        end
    end

    corr_sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (s1_addr_q),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .valid_o (fifo_vld),
        .count_o (fifo_cnt)
    );

    assign evt_ready  = rdy_q;
    assign inc_valid  = fifo_vld;
    assign inc_addr   = fifo_vld ? fifo_data : '0;
    assign accept_cnt = acc_cnt_q;
    assign reject_cnt = rej_cnt_q;
    assign range_cnt  = rng_cnt_q;

endmodule

// File: tb/tb_corr_bin_dispatcher.sv
// Bench for corr_bin_dispatcher: directed plan vectors plus a randomized
// scoreboard run against a signed-arithmetic reference model.
module tb_corr_bin_dispatcher;
    localparam int CH_W = 2, INT_W = 8, ADDR_W = 8, DEPTH = 4, CNT_W = 8;
    localparam int CMAX = (1 << CNT_W) - 1;
    localparam int AMAX = (1 << ADDR_W) - 1;
    localparam int CTR  = 1 << (ADDR_W - 1);

    logic clk = 1'b0, rst = 1'b1;
    logic cfg_enable = 1'b1, cfg_mirror = 1'b0;
    logic [CH_W-1:0] cfg_ref_ch = '0, cfg_probe_ch = 2'd1;
    logic evt_valid = 1'b0, evt_ready;
    logic [CH_W-1:0] evt_start_ch = '0, evt_end_ch = '0;
    logic [INT_W-1:0] evt_interval = '0;
    logic inc_valid, inc_ready = 1'b0;
    logic [ADDR_W-1:0] inc_addr;
    logic clr_cnt = 1'b0;
    logic [CNT_W-1:0] accept_cnt, reject_cnt, range_cnt;

    int n_vec = 0, n_err = 0;
    int exp_q[$];
    int m_acc, m_rej, m_rng;

    always #5 clk = ~clk;

    corr_bin_dispatcher #(.CH_W(CH_W), .INT_W(INT_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_mirror(cfg_mirror),
        .cfg_ref_ch(cfg_ref_ch), .cfg_probe_ch(cfg_probe_ch),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_start_ch(evt_start_ch),
        .evt_end_ch(evt_end_ch), .evt_interval(evt_interval),
        .inc_valid(inc_valid), .inc_ready(inc_ready), .inc_addr(inc_addr),
        .clr_cnt(clr_cnt), .accept_cnt(accept_cnt), .reject_cnt(reject_cnt), .range_cnt(range_cnt)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // kind: 0 request, 1 reject, 2 out of range, 3 dropped (disabled)
    function automatic void model(input int en, input int mir, input int r, input int p,
                                  input int s, input int e, input int iv,
                                  output int kind, output int addr);
        int d;
        bit fwd, rev;
        addr = 0;
        fwd = (s == r) && (e == p);
        rev = (s == p) && (e == r);
        if (en == 0) kind = 3;
        else if (!(fwd || rev)) kind = 1;
        else begin
            d = (fwd || mir != 0) ? iv : -iv;
            addr = CTR + d;
            kind = (addr >= 0 && addr <= AMAX) ? 0 : 2;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_vec++; if (evt_ready !== 1'b0) begin n_err++; $display("FAIL reset_evt_ready got %0b want 0", evt_ready); end
        n_vec++; if (inc_valid !== 1'b0) begin n_err++; $display("FAIL reset_inc_valid got %0b want 0", inc_valid); end
        n_vec++; if (inc_addr !== '0) begin n_err++; $display("FAIL reset_inc_addr got %0d want 0", inc_addr); end
        n_vec++; if (accept_cnt !== '0 || reject_cnt !== '0 || range_cnt !== '0) begin
            n_err++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", accept_cnt, reject_cnt, range_cnt);
        end
        rst = 1'b0;
        step();
        n_vec++; if (evt_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got %0b want 1", evt_ready); end
    endtask

    typedef struct { int en, mir, r, p, s, e, iv, kind, addr; } vec_t;

    task automatic test_directed();
        vec_t tbl[12];
        int ea = 0, er = 0, eg = 0, k;
        tbl[0]  = '{1, 0, 0, 1, 0, 1, 5,   0, 133};
        tbl[1]  = '{1, 0, 0, 1, 1, 0, 5,   0, 123};
        tbl[2]  = '{1, 0, 0, 1, 1, 0, 128, 0, 0};
        tbl[3]  = '{1, 0, 0, 1, 0, 1, 128, 2, 0};
        tbl[4]  = '{1, 1, 0, 1, 1, 0, 5,   0, 133};
        tbl[5]  = '{1, 0, 0, 1, 2, 3, 5,   1, 0};
        tbl[6]  = '{1, 0, 0, 1, 1, 0, 0,   0, 128};
        tbl[7]  = '{1, 0, 0, 1, 0, 1, 127, 0, 255};
        tbl[8]  = '{1, 0, 0, 1, 1, 0, 129, 2, 0};
        tbl[9]  = '{0, 0, 0, 1, 0, 1, 5,   3, 0};
        tbl[10] = '{1, 1, 0, 1, 1, 0, 128, 2, 0};
        tbl[11] = '{1, 0, 2, 2, 2, 2, 7,   0, 135};
        inc_ready = 1'b1;
        foreach (tbl[i]) begin
            cfg_enable   = tbl[i].en[0];
            cfg_mirror   = tbl[i].mir[0];
            cfg_ref_ch   = CH_W'(tbl[i].r);
            cfg_probe_ch = CH_W'(tbl[i].p);
            evt_start_ch = CH_W'(tbl[i].s);
            evt_end_ch   = CH_W'(tbl[i].e);
            evt_interval = INT_W'(tbl[i].iv);
            k = 0;
            while (evt_ready !== 1'b1 && k < 20) begin step(); k++; end
            n_vec++; if (evt_ready !== 1'b1) begin n_err++; $display("FAIL dir%0d_ready_timeout got %0b want 1", i, evt_ready); end
            evt_valid = 1'b1;
            step();
            evt_valid = 1'b0;
            n_vec++; if (inc_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_latency got inc_valid %0b want 0", i, inc_valid); end
            step();
            if (tbl[i].kind == 0) begin
                n_vec++; if (inc_valid !== 1'b1 || int'(inc_addr) != tbl[i].addr) begin
                    n_err++; $display("FAIL dir%0d_addr got v=%0b a=%0d want v=1 a=%0d", i, inc_valid, inc_addr, tbl[i].addr);
                end
            end else begin
                n_vec++; if (inc_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_no_req got inc_valid %0b want 0", i, inc_valid); end
            end
            step();
            case (tbl[i].kind)
                0: ea++;
                1: er++;
                2: eg++;
                default: ;
            endcase
            n_vec++; if (int'(accept_cnt) != ea || int'(reject_cnt) != er || int'(range_cnt) != eg) begin
                n_err++; $display("FAIL dir%0d_counters got %0d/%0d/%0d want %0d/%0d/%0d", i, accept_cnt, reject_cnt, range_cnt, ea, er, eg);
            end
        end
        cfg_enable = 1'b1; cfg_mirror = 1'b0; cfg_ref_ch = 2'd0; cfg_probe_ch = 2'd1;
    endtask

    task automatic test_fill();
        int accepted = 0, iv = 1;
        int want[$];
        int got[$];
        inc_ready = 1'b0;
        evt_start_ch = 2'd0; evt_end_ch = 2'd1;
        evt_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            evt_interval = INT_W'(iv);
            if (evt_ready === 1'b1) begin
                accepted++;
                want.push_back(CTR + iv);
                step();
                iv++;
            end else step();
        end
        evt_valid = 1'b0;
        n_vec++; if (accepted != DEPTH) begin n_err++; $display("FAIL fill_accepted got %0d want %0d", accepted, DEPTH); end
        n_vec++; if (evt_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready got %0b want 0", evt_ready); end
        inc_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (inc_valid === 1'b1) got.push_back(int'(inc_addr));
            step();
        end
        n_vec++; if (got.size() != want.size()) begin n_err++; $display("FAIL fill_drain_count got %0d want %0d", got.size(), want.size()); end
        for (int j = 0; j < want.size() && j < got.size(); j++) begin
            n_vec++; if (got[j] != want[j]) begin n_err++; $display("FAIL fill_order%0d got %0d want %0d", j, got[j], want[j]); end
        end
        n_vec++; if (evt_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_back got %0b want 1", evt_ready); end
    endtask

    task automatic test_back_to_back();
        int kind, addr, e, cyc;
        bit prev_stall = 0;
        logic [ADDR_W-1:0] prev_addr = '0;
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        m_acc = 0; m_rej = 0; m_rng = 0;
        exp_q.delete();
        for (int c = 0; c < 800; c++) begin
            evt_valid    = ($urandom_range(0, 3) != 0);
            evt_start_ch = ($urandom_range(0, 4) != 0) ? CH_W'($urandom_range(0, 1)) : CH_W'($urandom_range(0, 3));
            evt_end_ch   = ($urandom_range(0, 4) != 0) ? CH_W'($urandom_range(0, 1)) : CH_W'($urandom_range(0, 3));
            evt_interval = ($urandom_range(0, 7) == 0) ? INT_W'($urandom_range(0, 1)) : INT_W'($urandom_range(0, 255));
            cfg_mirror   = 1'($urandom_range(0, 1));
            cfg_enable   = ($urandom_range(0, 9) != 0);
            cfg_ref_ch   = ($urandom_range(0, 9) == 0) ? CH_W'($urandom_range(0, 3)) : 2'd0;
            cfg_probe_ch = ($urandom_range(0, 9) == 0) ? CH_W'($urandom_range(0, 3)) : 2'd1;
            inc_ready    = 1'($urandom_range(0, 1));
            if (prev_stall) begin
                n_vec++; if (inc_valid !== 1'b1 || inc_addr !== prev_addr) begin
                    n_err++; $display("FAIL b2b_stall_hold c%0d got v=%0b a=%0d want v=1 a=%0d", c, inc_valid, inc_addr, prev_addr);
                end
            end
            if (inc_valid === 1'b1 && inc_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_spurious c%0d got a=%0d want none", c, inc_addr); end
                else begin
                    e = exp_q.pop_front();
                    if (int'(inc_addr) != e) begin n_err++; $display("FAIL b2b_addr c%0d got %0d want %0d", c, inc_addr, e); end
                end
            end
            prev_stall = (inc_valid === 1'b1) && !inc_ready;
            prev_addr  = inc_addr;
            if (evt_valid && evt_ready === 1'b1) begin
                model(int'(cfg_enable), int'(cfg_mirror), int'(cfg_ref_ch), int'(cfg_probe_ch),
                      int'(evt_start_ch), int'(evt_end_ch), int'(evt_interval), kind, addr);
                case (kind)
                    0: begin exp_q.push_back(addr); m_acc = sat(m_acc); end
                    1: m_rej = sat(m_rej);
                    2: m_rng = sat(m_rng);
                    default: ;
                endcase
            end
            step();
        end
        evt_valid = 1'b0; inc_ready = 1'b1;
        cyc = 0;
        while (cyc < 20) begin
            if (inc_valid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_drain_spurious got a=%0d want none", inc_addr); end
                else begin
                    e = exp_q.pop_front();
                    if (int'(inc_addr) != e) begin n_err++; $display("FAIL b2b_drain_addr got %0d want %0d", inc_addr, e); end
                end
            end
            step();
            cyc++;
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_lost got %0d pending want 0", exp_q.size()); end
        n_vec++; if (int'(accept_cnt) != m_acc || int'(reject_cnt) != m_rej || int'(range_cnt) != m_rng) begin
            n_err++; $display("FAIL b2b_counters got %0d/%0d/%0d want %0d/%0d/%0d", accept_cnt, reject_cnt, range_cnt, m_acc, m_rej, m_rng);
        end
        cfg_enable = 1'b1; cfg_mirror = 1'b0; cfg_ref_ch = 2'd0; cfg_probe_ch = 2'd1;
    endtask

    task automatic test_reset_mid();
        int sent = 0, k = 0;
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        inc_ready = 1'b0;
        evt_start_ch = 2'd0; evt_end_ch = 2'd1;
        while (sent < 3 && k < 20) begin
            evt_interval = INT_W'(10 + sent);
            evt_valid = 1'b1;
            if (evt_ready === 1'b1) sent++;
            step();
            k++;
        end
        evt_valid = 1'b0;
        step(); step();
        n_vec++; if (inc_valid !== 1'b1 || int'(accept_cnt) != 3) begin
            n_err++; $display("FAIL mid_queued got v=%0b acc=%0d want v=1 acc=3", inc_valid, accept_cnt);
        end
        rst = 1'b1;
        step();
        n_vec++; if (inc_valid !== 1'b0 || inc_addr !== '0) begin
            n_err++; $display("FAIL mid_withdrawn got v=%0b a=%0d want v=0 a=0", inc_valid, inc_addr);
        end
        n_vec++; if (accept_cnt !== '0 || evt_ready !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_state got acc=%0d rdy=%0b want acc=0 rdy=0", accept_cnt, evt_ready);
        end
        rst = 1'b0;
        inc_ready = 1'b1;
        step();
        n_vec++; if (evt_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_back got %0b want 1", evt_ready); end
        step();
        n_vec++; if (inc_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_stale got v=%0b want 0", inc_valid); end
    endtask

    task automatic test_saturate();
        int accepted = 0, k;
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        inc_ready = 1'b1;
        evt_start_ch = 2'd0; evt_end_ch = 2'd1; evt_interval = INT_W'(5);
        evt_valid = 1'b1;
        for (int c = 0; c < 320; c++) begin
            if (evt_ready === 1'b1) accepted++;
            step();
        end
        evt_valid = 1'b0;
        step(); step(); step();
        n_vec++; if (int'(accept_cnt) != ((accepted > CMAX) ? CMAX : accepted)) begin
            n_err++; $display("FAIL sat_accept got %0d want %0d", accept_cnt, (accepted > CMAX) ? CMAX : accepted);
        end
        n_vec++; if (accepted <= CMAX) begin n_err++; $display("FAIL sat_throughput got %0d accepts want >%0d", accepted, CMAX); end
        k = 0;
        while (evt_ready !== 1'b1 && k < 20) begin step(); k++; end
        clr_cnt = 1'b1;
        evt_valid = 1'b1;
        step();
        clr_cnt = 1'b0;
        evt_valid = 1'b0;
        step(); step(); step();
        n_vec++; if (accept_cnt !== '0 || reject_cnt !== '0 || range_cnt !== '0) begin
            n_err++; $display("FAIL sat_clear got %0d/%0d/%0d want 0/0/0", accept_cnt, reject_cnt, range_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_fill();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
